// File: rtl/zigzag_scan_ctrl_if.sv
// Stream bundle between the raster-order coefficient source, the zigzag reorder controller and the entropy coder.
// With ZZ_STATS_EN defined the bundle also carries the per-block nonzero count.
interface zigzag_scan_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] coef_in;
  logic                  coef_valid_in;
  logic                  coef_ready_out;
  logic [DATA_WIDTH-1:0] coef_out;
  logic                  coef_valid_out;
  logic                  coef_ready_in;
  logic                  coef_last_out;
  logic                  busy_out;
`ifdef ZZ_STATS_EN
  logic [6:0]            nz_count_out;

  modport master (
    output coef_in, coef_valid_in, coef_ready_in,
    input  coef_ready_out, coef_out, coef_valid_out, coef_last_out, busy_out, nz_count_out
  );
  modport slave (
    input  coef_in, coef_valid_in, coef_ready_in,
    output coef_ready_out, coef_out, coef_valid_out, coef_last_out, busy_out, nz_count_out
  );
`else
  modport master (
    output coef_in, coef_valid_in, coef_ready_in,
    input  coef_ready_out, coef_out, coef_valid_out, coef_last_out, busy_out
  );
  modport slave (
    input  coef_in, coef_valid_in, coef_ready_in,
    output coef_ready_out, coef_out, coef_valid_out, coef_last_out, busy_out
  );
`endif
endinterface

// File: rtl/zigzag_scan_ctrl.sv
// Ping-pong raster-to-zigzag reorder buffer: two 64-entry banks, 3-stage registered read pipeline.
// Optional ZZ_STATS_EN adds a per-block nonzero coefficient count presented with the block's last output.
module zigzag_scan_ctrl #(
  parameter int unsigned DATA_WIDTH = 12
) (
  input logic              clk_in,
  input logic              rst_in,
  zigzag_scan_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
  typedef enum logic {R_IDLE, R_RUN} rd_st_e;

  // Column-first zigzag: scan position -> raster address.
  localparam logic [IDX_W-1:0] ZZ_TABLE [DEPTH] = '{
    6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17,
    6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
    6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20,
    6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
    6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36,
    6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
    6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
  };

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  bank_st_e              bank_q [2], bank_d [2];
  rd_st_e                rd_st_q, rd_st_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]      s1_addr_q, s1_addr_d;
  logic                  s1_bank_q, s1_bank_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_bank_q, s2_bank_d;
  logic                  s2_last_q, s2_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_bank_q, out_bank_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic wr_hs_c, out_hs_c, stall_c;

  assign wr_hs_c  = bus.coef_valid_in && ready_q;
  assign out_hs_c = out_valid_q && bus.coef_ready_in;
  assign stall_c  = out_valid_q && !bus.coef_ready_in;

  // Bank data storage; no reset, validity is tracked by bank state.
  always_ff @(posedge clk_in) begin
    if (wr_hs_c) begin
      mem_q[wr_bank_q][wr_cnt_q] <= bus.coef_in;
    end
  end

  // Next-state: bank bookkeeping, read FSM and pipeline advance.
  always_comb begin
    bank_d      = bank_q;
    rd_st_d     = rd_st_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    scan_idx_d  = scan_idx_q;
    s1_valid_d  = s1_valid_q;
    s1_addr_d   = s1_addr_q;
    s1_bank_d   = s1_bank_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_bank_d   = s2_bank_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_bank_d  = out_bank_q;

    if (wr_hs_c) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        bank_d[wr_bank_q] = B_FULL;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = B_FILLING;
      end
    end

    if (out_hs_c && out_last_q) begin
      bank_d[out_bank_q] = B_EMPTY;
    end

    if (!stall_c) begin
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      if (rd_st_q == R_RUN) begin
        s1_valid_d = 1'b1;
        s1_addr_d  = ZZ_TABLE[scan_idx_q];
        s1_bank_d  = rd_bank_q;
        s1_last_d  = (scan_idx_q == 6'd63);
      end
      s2_valid_d  = s1_valid_q;
      s2_data_d   = mem_q[s1_bank_q][s1_addr_q];
      s2_bank_d   = s1_bank_q;
      s2_last_d   = s1_valid_q && s1_last_q;
      out_valid_d = s2_valid_q;
      out_last_d  = s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        out_data_d = s2_data_q;
        out_bank_d = s2_bank_q;
      end
    end

    case (rd_st_q)
      R_IDLE: begin
        if (bank_q[rd_bank_q] == B_FULL) begin
          rd_st_d           = R_RUN;
          scan_idx_d        = '0;
          bank_d[rd_bank_q] = B_DRAINING;
        end
      end
      R_RUN: begin
        if (!stall_c) begin
          scan_idx_d = scan_idx_q + 6'd1;
          if (scan_idx_q == 6'd63) begin
            rd_bank_d = ~rd_bank_q;
            // Chain straight into the other bank when it is already complete.
            if (bank_q[~rd_bank_q] == B_FULL) begin
              bank_d[~rd_bank_q] = B_DRAINING;
            end else begin
              rd_st_d = R_IDLE;
            end
          end
        end
      end
      default: rd_st_d = R_IDLE;
    endcase

    ready_d = (bank_d[wr_bank_d] == B_EMPTY) || (bank_d[wr_bank_d] == B_FILLING);
    busy_d  = (bank_d[0] != B_EMPTY) || (bank_d[1] != B_EMPTY) ||
              s1_valid_d || s2_valid_d || out_valid_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bank_q      <= '{default: B_EMPTY};
      rd_st_q     <= R_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      scan_idx_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_bank_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_bank_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_bank_q  <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      rd_st_q     <= rd_st_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      scan_idx_q  <= scan_idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_bank_q   <= s1_bank_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_bank_q   <= s2_bank_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_bank_q  <= out_bank_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.coef_ready_out = ready_q;
  assign bus.coef_out       = out_data_q;
  assign bus.coef_valid_out = out_valid_q;
  assign bus.coef_last_out  = out_last_q;
  assign bus.busy_out       = busy_q;

`ifdef ZZ_STATS_EN
  localparam int unsigned NZ_W = 7;

  logic [NZ_W-1:0] nz_cnt_q, nz_cnt_d;
  logic [NZ_W-1:0] nz_bank_q [2], nz_bank_d [2];
  logic [NZ_W-1:0] nz_out_q, nz_out_d;

  // Nonzero count per filling bank, frozen when the bank completes.
  always_comb begin
    nz_cnt_d  = nz_cnt_q;
    nz_bank_d = nz_bank_q;
    nz_out_d  = nz_out_q;
    if (wr_hs_c) begin
      if (wr_cnt_q == 6'd63) begin
        nz_bank_d[wr_bank_q] = nz_cnt_q + NZ_W'(bus.coef_in != '0);
        nz_cnt_d             = '0;
      end else begin
        nz_cnt_d = nz_cnt_q + NZ_W'(bus.coef_in != '0);
      end
    end
    if (!stall_c && s2_valid_q) begin
      nz_out_d = nz_bank_q[s2_bank_q];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      nz_cnt_q  <= '0;
      nz_bank_q <= '{default: '0};
      nz_out_q  <= '0;
    end else begin
      nz_cnt_q  <= nz_cnt_d;
      nz_bank_q <= nz_bank_d;
      nz_out_q  <= nz_out_d;
    end
  end

  assign bus.nz_count_out = nz_out_q;
`endif

endmodule
